addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor with runtime ADD/SUB mode,
//  carry in/out, signed overflow and valid/ready handshake on both sides.
//  Successor to the fixed 4-bit combinational subtractor.
//  Sits between operand sources and the datapath; each chunk maps onto the iCE40 LUT+SB_CARRY chain.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; >= 2
//  STAGES  2  pipeline stages = carry-chain chunks; WIDTH % STAGES == 0; 1..WIDTH
// PORTS
//  CLK          in   1      clock, all state on rising edge
//  ASYNCRESETN  in   1      asynchronous active-low reset
//  I_VALID      in   1      operand beat valid
//  I_READY      out  1      unit can accept a beat this cycle
//  I0           in   WIDTH  minuend / augend
//  I1           in   WIDTH  subtrahend / addend
//  SUB          in   1      0: O=I0+I1+CIN; 1: O=I0+~I1+CIN
//  CIN          in   1      carry in; SUB=1 with CIN=1 gives plain I0-I1
//  O_VALID      out  1      result beat valid
//  O_READY      in   1      consumer accepts result
//  O            out  WIDTH  result
//  COUT         out  1      carry out of MSB (raw; for SUB, 1 = no borrow)
//  OV           out  1      signed overflow of the full-width operation
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all stage valid bits 0, O_VALID=0,
//    O/COUT/OV=0, I_READY=1 after deassert.
//  - CW = WIDTH/STAGES. Stage k adds bits [k*CW +: CW] with carry from stage k-1's register.
//  - Operand skew: upper chunks of I0/~I1 are delayed through per-stage registers.
//    Deskew: completed lower result chunks are delayed to emerge aligned.
//  - Global stall: ADV = O_READY | ~O_VALID; I_READY = ADV. All stages shift only when ADV=1.
//    Beat accepted when I_VALID & I_READY.
//  - Latency: exactly STAGES cycles from acceptance to O_VALID when no stall.
//    Throughput 1 beat/cycle.
//  - Bubbles propagate as valid=0 stages. No collapse; a bubble costs one slot.
//  - O/COUT/OV stable while O_VALID & ~O_READY. Data regs may update freely when valid=0.
//  - OV = (a[W-1]==b'[W-1]) & (s[W-1]!=a[W-1]), b' = SUB ? ~I1 : I1.
//  - SUB and CIN are sampled with the operands. Mode may change every beat, no penalty.
//  - Simultaneous accept+emit when full and O_READY=1: no loss, no duplication.
//  - Reset mid-operation drops all in-flight beats. No output for them after reset.
// CONFIGURATION
//  ADDSUB_SATURATE_EN defined:
//   - when OV=1, O clamps to 2^(W-1)-1 if a[W-1]=0, else -2^(W-1).
//   - OV still reports the overflow; COUT is unchanged.
//   - Clamp is applied in the last stage; latency is unchanged.
//  Not defined: O wraps modulo 2^WIDTH; no saturation logic is generated.
// STRUCTURE
//  - Package addsub_pkg: typedef op_e {OP_ADD=0, OP_SUB=1}; function chunk_w(WIDTH,STAGES).
//    Also holds localparam checks (WIDTH%STAGES==0) used by an elaboration assertion.
//  - Sub-module addsub_chunk #(CW): combinational CW-bit ripple adder (A,B,CIN -> S,COUT,
//    plus MSB operand bits for OV), one instance per stage.
//  - Top owns skew/deskew registers, valid shift chain, stall logic, OV/saturation.
// TESTING
//  1 W=8,S=2: I0=0x05,I1=0x03,SUB=1,CIN=1 -> after 2 cycles O=0x02,COUT=1,OV=0
//  2 W=8,S=2: I0=0x7F,I1=0x01,SUB=0,CIN=0 -> O=0x80,OV=1 (0x7F with ADDSUB_SATURATE_EN)
//  3 W=8,S=4: I0=0x00,I1=0x01,SUB=1,CIN=1 -> O=0xFF,COUT=0,OV=0; carry crosses all chunks
//  4 Back-to-back 16 random beats, O_READY=1 -> one result/cycle, in order, vs golden model
//  5 O_READY=0 for 5 cycles, pipe full -> I_READY=0, O held stable, resume loses nothing
//  6 ASYNCRESETN low mid-stream with 2 beats in flight -> O_VALID=0 at once, none emitted later

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int MIN_WIDTH = 32'sd2;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= MIN_WIDTH) && (stages >= 32'sd1) && (stages <= width) &&
           ((width % stages) == 32'sd0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit ripple adder slice; one slice per pipeline stage.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          a_msb,
  output logic          b_msb
);

  logic [CW:0] c_s;

  // Ripple the carry through the slice one bit at a time.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < CW; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c_s[CW];
  assign a_msb = a[CW-1];
  assign b_msb = b[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub, one carry-chain chunk per stage with operand skew and result deskew.
// Define ADDSUB_SATURATE_EN to clamp signed overflow in the last stage instead of wrapping.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             SUB,
  input  logic             CIN,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             OV
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of STAGES");
  end

  op_e              op_s;
  logic             adv_s;
  logic             ov_s;
  logic [WIDTH-1:0] o_nxt_s;

  logic [WIDTH-1:0] a_in_s    [STAGES];
  logic [WIDTH-1:0] b_in_s    [STAGES];
  logic [WIDTH-1:0] res_in_s  [STAGES];
  logic [WIDTH-1:0] res_nxt_s [STAGES];
  logic             cin_s     [STAGES];
  logic             vld_in_s  [STAGES];
  logic [CW-1:0]    sum_s     [STAGES];
  logic             cout_s    [STAGES];
  logic             a_msb_s   [STAGES];
  logic             b_msb_s   [STAGES];

  logic [WIDTH-1:0] a_r     [STAGES];
  logic [WIDTH-1:0] b_r     [STAGES];
  logic [WIDTH-1:0] res_r   [STAGES];
  logic             carry_r [STAGES];
  logic             vld_r   [STAGES];
  logic [WIDTH-1:0] o_r;
  logic             cout_r;
  logic             ov_r;

  assign op_s  = op_e'(SUB);
  assign adv_s = O_READY | ~vld_r[STAGES-1];

  // Stage 0 takes the ports; every later stage reads its predecessor's registers.
  always_comb begin
    a_in_s[0]   = I0;
    b_in_s[0]   = (op_s == OP_SUB) ? ~I1 : I1;
    cin_s[0]    = CIN;
    vld_in_s[0] = I_VALID;
    res_in_s[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      a_in_s[i]   = a_r[i-1];
      b_in_s[i]   = b_r[i-1];
      cin_s[i]    = carry_r[i-1];
      vld_in_s[i] = vld_r[i-1];
      res_in_s[i] = res_r[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chunk
    addsub_chunk #(
      .CW(CW)
    ) u_chunk (
      .a    (a_in_s[g][g*CW +: CW]),
      .b    (b_in_s[g][g*CW +: CW]),
      .cin  (cin_s[g]),
      .s    (sum_s[g]),
      .cout (cout_s[g]),
      .a_msb(a_msb_s[g]),
      .b_msb(b_msb_s[g])
    );
  end

  // Splice each stage's fresh chunk into the lower result bits it inherited.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      res_nxt_s[i]             = res_in_s[i];
      res_nxt_s[i][i*CW +: CW] = sum_s[i];
    end
  end

  // Signed overflow from the MSB operands and MSB of the sum, with optional clamp.
  always_comb begin
    ov_s = (a_msb_s[STAGES-1] == b_msb_s[STAGES-1]) &
           (res_nxt_s[STAGES-1][WIDTH-1] != a_msb_s[STAGES-1]);
`ifdef ADDSUB_SATURATE_EN
    if (ov_s) begin
      o_nxt_s = a_msb_s[STAGES-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      o_nxt_s = res_nxt_s[STAGES-1];
    end
`else
    o_nxt_s = res_nxt_s[STAGES-1];
`endif
  end

  // All stages shift together, and only when the output side can advance.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_r[i]   <= 1'b0;
        carry_r[i] <= 1'b0;
        a_r[i]     <= '0;
        b_r[i]     <= '0;
        res_r[i]   <= '0;
      end
      o_r    <= '0;
      cout_r <= 1'b0;
      ov_r   <= 1'b0;
    end else if (adv_s) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_r[i]   <= vld_in_s[i];
        carry_r[i] <= cout_s[i];
        a_r[i]     <= a_in_s[i];
        b_r[i]     <= b_in_s[i];
        res_r[i]   <= res_nxt_s[i];
      end
      o_r    <= o_nxt_s;
      cout_r <= cout_s[STAGES-1];
      ov_r   <= ov_s;
    end
  end

  assign I_READY = adv_s;
  assign O_VALID = vld_r[STAGES-1];
  assign O       = o_r;
  assign COUT    = cout_r;
  assign OV      = ov_r;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench: 2-stage and 4-stage instances share stimulus, checked against an integer model.
module tb_addsub_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [W-1:0] i0, i1;
  logic         sub, cin, o_ready;

  logic         i_ready2, o_valid2, cout2, ov2;
  logic [W-1:0] o2;
  logic         i_ready4, o_valid4, cout4, ov4;
  logic [W-1:0] o4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(2)) dut2 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(i_valid), .I_READY(i_ready2),
    .I0(i0), .I1(i1), .SUB(sub), .CIN(cin), .O_VALID(o_valid2), .O_READY(o_ready),
    .O(o2), .COUT(cout2), .OV(ov2)
  );

  addsub_pipe #(.WIDTH(W), .STAGES(4)) dut4 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(i_valid), .I_READY(i_ready4),
    .I0(i0), .I1(i1), .SUB(sub), .CIN(cin), .O_VALID(o_valid4), .O_READY(o_ready),
    .O(o4), .COUT(cout4), .OV(ov4)
  );

  // Reference: plain unsigned and signed integer arithmetic; returns {ov, cout, o}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    logic [W-1:0] bv;
    int unsigned  uns;
    int           sa, sb, ci, sgn;
    logic [W-1:0] o;
    logic         v;
    bv  = s ? ~b : b;
    uns = a + bv + c;
    sa  = $signed(a);
    sb  = $signed(bv);
    ci  = c;
    sgn = sa + sb + ci;
    o   = uns[W-1:0];
    v   = (sgn > 127) || (sgn < -128);
`ifdef ADDSUB_SATURATE_EN
    if (v) o = (sgn > 0) ? 8'h7F : 8'h80;
`endif
    return {v, uns[W], o};
  endfunction

  task automatic set_idle();
    i_valid = 1'b0; i0 = 8'h00; i1 = 8'h00; sub = 1'b0; cin = 1'b0;
  endtask

  task automatic rand_beat();
    i0 = 8'($urandom); i1 = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask

  // Drive one beat into an empty pipe and observe what each instance emits afterwards.
  task automatic one_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic c, output int lat2, output int lat4,
                          output logic [W+1:0] got2, output logic [W+1:0] got4,
                          output int nv2, output int nv4);
    @(posedge clk); #1;
    i_valid = 1'b1; i0 = a; i1 = b; sub = s; cin = c; o_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat2 = -1; lat4 = -1; nv2 = 0; nv4 = 0; got2 = '0; got4 = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (o_valid2) begin
        nv2++;
        if (lat2 < 0) begin lat2 = n; got2 = {ov2, cout2, o2}; end
      end
      if (o_valid4) begin
        nv4++;
        if (lat4 < 0) begin lat4 = n; got4 = {ov4, cout4, o4}; end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    set_idle();
    o_ready = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({o_valid2, o2, cout2, ov2} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_state2: got %b expected %b", {o_valid2, o2, cout2, ov2}, 11'b0);
    end
    n_tests++;
    if ({o_valid4, o4, cout4, ov4} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_state4: got %b expected %b", {o_valid4, o4, cout4, ov4}, 11'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({i_ready2, i_ready4, o_valid2, o_valid4} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1100", {i_ready2, i_ready4, o_valid2, o_valid4});
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         c;
    logic [W+1:0] e;
  } vec_t;

  task automatic test_vectors();
    vec_t         vecs [4];
    int           lat2, lat4, nv2, nv4;
    logic [W+1:0] got2, got4;
    vecs[0] = '{a: 8'h05, b: 8'h03, s: 1'b1, c: 1'b1, e: {1'b0, 1'b1, 8'h02}};
    vecs[2] = '{a: 8'h00, b: 8'h01, s: 1'b1, c: 1'b1, e: {1'b0, 1'b0, 8'hFF}};
`ifdef ADDSUB_SATURATE_EN
    vecs[1] = '{a: 8'h7F, b: 8'h01, s: 1'b0, c: 1'b0, e: {1'b1, 1'b0, 8'h7F}};
    vecs[3] = '{a: 8'h80, b: 8'h01, s: 1'b1, c: 1'b1, e: {1'b1, 1'b1, 8'h80}};
`else
    vecs[1] = '{a: 8'h7F, b: 8'h01, s: 1'b0, c: 1'b0, e: {1'b1, 1'b0, 8'h80}};
    vecs[3] = '{a: 8'h80, b: 8'h01, s: 1'b1, c: 1'b1, e: {1'b1, 1'b1, 8'h7F}};
`endif
    for (int v = 0; v < 4; v++) begin
      one_beat(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].c, lat2, lat4, got2, got4, nv2, nv4);
      n_tests++;
      if (got2 !== vecs[v].e) begin
        n_fail++; $display("FAIL vec%0d_s2 {ov,cout,o}: got %h expected %h", v, got2, vecs[v].e);
      end
      n_tests++;
      if (got4 !== vecs[v].e) begin
        n_fail++; $display("FAIL vec%0d_s4 {ov,cout,o}: got %h expected %h", v, got4, vecs[v].e);
      end
      n_tests++;
      if ({lat2, nv2} !== {32'sd1, 32'sd1}) begin
        n_fail++; $display("FAIL vec%0d_s2 latency/count: got %0d/%0d expected 1/1", v, lat2, nv2);
      end
      n_tests++;
      if ({lat4, nv4} !== {32'sd3, 32'sd1}) begin
        n_fail++; $display("FAIL vec%0d_s4 latency/count: got %0d/%0d expected 3/1", v, lat4, nv4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q2 [$];
    logic [W+1:0] q4 [$];
    logic [W+1:0] e;
    int first2 = -1, last2 = -1, cnt2 = 0;
    int first4 = -1, last4 = -1, cnt4 = 0;
    o_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc < 16) begin i_valid = 1'b1; rand_beat(); end
      else set_idle();
      @(negedge clk);
      if (o_valid2) begin
        e = (q2.size() > 0) ? q2.pop_front() : '1;
        n_tests++;
        if ({ov2, cout2, o2} !== e) begin
          n_fail++; $display("FAIL b2b_s2 beat%0d: got %h expected %h", cnt2, {ov2, cout2, o2}, e);
        end
        if (first2 < 0) first2 = cyc;
        last2 = cyc; cnt2++;
      end
      if (o_valid4) begin
        e = (q4.size() > 0) ? q4.pop_front() : '1;
        n_tests++;
        if ({ov4, cout4, o4} !== e) begin
          n_fail++; $display("FAIL b2b_s4 beat%0d: got %h expected %h", cnt4, {ov4, cout4, o4}, e);
        end
        if (first4 < 0) first4 = cyc;
        last4 = cyc; cnt4++;
      end
      if (i_valid && i_ready2) q2.push_back(model(i0, i1, sub, cin));
      if (i_valid && i_ready4) q4.push_back(model(i0, i1, sub, cin));
      @(posedge clk); #1;
    end
    n_tests++;
    if (cnt2 != 16 || last2 - first2 != 15 || first2 != 2) begin
      n_fail++; $display("FAIL b2b_s2 stream: got count %0d first %0d last %0d expected 16/2/17", cnt2, first2, last2);
    end
    n_tests++;
    if (cnt4 != 16 || last4 - first4 != 15 || first4 != 4) begin
      n_fail++; $display("FAIL b2b_s4 stream: got count %0d first %0d last %0d expected 16/4/19", cnt4, first4, last4);
    end
  endtask

  task automatic test_stall();
    logic [W+1:0] q2 [$];
    logic [W+1:0] q4 [$];
    int acc2 = 0, acc4 = 0, stall2 = 0, stall4 = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 12) begin i_valid = 1'b1; rand_beat(); end
      else set_idle();
      o_ready = !(cyc >= 4 && cyc < 9);
      @(negedge clk);
      if (o_valid2) begin
        n_tests++;
        if (q2.size() == 0 || {ov2, cout2, o2} !== q2[0]) begin
          n_fail++; $display("FAIL stall_s2 data cyc%0d: got %h expected %h", cyc, {ov2, cout2, o2},
                             (q2.size() > 0) ? q2[0] : '1);
        end
        if (!o_ready) begin
          stall2++;
          n_tests++;
          if (i_ready2 !== 1'b0) begin
            n_fail++; $display("FAIL stall_s2 i_ready cyc%0d: got %b expected 0", cyc, i_ready2);
          end
        end else if (q2.size() > 0) begin
          void'(q2.pop_front());
        end
      end
      if (o_valid4) begin
        n_tests++;
        if (q4.size() == 0 || {ov4, cout4, o4} !== q4[0]) begin
          n_fail++; $display("FAIL stall_s4 data cyc%0d: got %h expected %h", cyc, {ov4, cout4, o4},
                             (q4.size() > 0) ? q4[0] : '1);
        end
        if (!o_ready) begin
          stall4++;
          n_tests++;
          if (i_ready4 !== 1'b0) begin
            n_fail++; $display("FAIL stall_s4 i_ready cyc%0d: got %b expected 0", cyc, i_ready4);
          end
        end else if (q4.size() > 0) begin
          void'(q4.pop_front());
        end
      end
      if (i_valid && i_ready2) begin q2.push_back(model(i0, i1, sub, cin)); acc2++; end
      if (i_valid && i_ready4) begin q4.push_back(model(i0, i1, sub, cin)); acc4++; end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    n_tests++;
    if (acc2 != 7 || stall2 != 5 || q2.size() != 0) begin
      n_fail++; $display("FAIL stall_s2 totals: got acc %0d stall %0d left %0d expected 7/5/0", acc2, stall2, q2.size());
    end
    n_tests++;
    if (acc4 != 7 || stall4 != 5 || q4.size() != 0) begin
      n_fail++; $display("FAIL stall_s4 totals: got acc %0d stall %0d left %0d expected 7/5/0", acc4, stall4, q4.size());
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b1; rand_beat();
    @(posedge clk); #1;
    rand_beat();
    @(posedge clk); #1;
    set_idle();
    n_tests++;
    if ({o_valid2, o_valid4} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_inflight: got %b expected 10", {o_valid2, o_valid4});
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_valid2, o_valid4, o2, cout2, ov2} !== {2'b00, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rstmid_clear: got %b expected 0", {o_valid2, o_valid4, o2, cout2, ov2});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_valid2 || o_valid4 || !i_ready2 || !i_ready4) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rstmid_no_output: got %0d cycles with output/stall expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
